// File: rtl/music_sequencer_pkg.sv
// Shared definitions for the music sequencer.
// Holds the FSM state codes, the tempo selector codes, the rest encoding and
// the two compile-time helpers that turn the clock frequency into a 1 ms tick
// length and into the phase-accumulator increment for 1 Hz.
package music_sequencer_pkg;

  // FSM state codes, kept as plain constants so older tools can share them
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_PAUSE = 2'd3;

  // Tempo selector codes; the spare code plays at normal speed
  typedef enum logic [1:0] {
    TEMPO_X1     = 2'b00,
    TEMPO_HALF   = 2'b01,
    TEMPO_DOUBLE = 2'b10,
    TEMPO_SPARE  = 2'b11
  } tempo_e;

  // A note whose frequency field is zero is a rest
  localparam int REST_FREQ = 0;

  // Clock cycles per (tempo-scaled) millisecond tick
  function automatic logic [31:0] tick_cycles(input int unsigned clkHz,
                                              input logic [1:0] tempo);
    logic [31:0] base;
    base = 32'(clkHz / 1000);
    case (tempo)
      TEMPO_HALF:   tick_cycles = base >> 1;
      TEMPO_DOUBLE: tick_cycles = base << 1;
      default:      tick_cycles = base;
    endcase
  endfunction

  // round(2^accW / clkHz): accumulator step that produces 1 Hz
  function automatic logic [63:0] phase_inc(input logic [63:0] clkHz,
                                            input int unsigned accW);
    phase_inc = ((64'd1 << accW) + (clkHz >> 1)) / clkHz;
  endfunction

endpackage

// File: rtl/music_sequencer_if.sv
// Control/status bundle between the board control logic and the sequencer.
// master: the controller (drives note writes and playback controls).
// slave:  the sequencer (drives pwm, busy, paused, done, cur_index).
interface music_sequencer_if #(
  parameter int IDX_W  = 8,
  parameter int FREQ_W = 12,
  parameter int DUR_W  = 12
);
  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [FREQ_W-1:0] wr_freq;
  logic [DUR_W-1:0]  wr_dur;
  logic [IDX_W:0]    song_len;
  logic              start;
  logic              pause;
  logic              abort;
  logic              loop_en;
  logic [1:0]        tempo_sel;
  logic              pwm;
  logic              busy;
  logic              paused;
  logic              done;
  logic [IDX_W-1:0]  cur_index;

  modport master (
    output wr_en, wr_addr, wr_freq, wr_dur, song_len, start, pause, abort,
           loop_en, tempo_sel,
    input  pwm, busy, paused, done, cur_index
  );

  modport slave (
    input  wr_en, wr_addr, wr_freq, wr_dur, song_len, start, pause, abort,
           loop_en, tempo_sel,
    output pwm, busy, paused, done, cur_index
  );
endinterface

// File: rtl/music_sequencer_tone_gen.sv
// Phase-accumulator square-wave generator.
// Ports: clk, reset (sync, active high); i_clear zeroes the accumulator;
// i_enable advances it and un-gates the output; i_freq is the tone in Hz
// (0 = rest); o_pwm is the accumulator MSB, forced low when disabled or resting.
module tone_gen
  import music_sequencer_pkg::*;
#(
  parameter int             FREQ_W = 12,
  parameter int             ACC_W  = 32,
  parameter logic [ACC_W-1:0] INC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic [FREQ_W-1:0] i_freq,
  output logic              o_pwm
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_step;

  // The product deliberately wraps modulo 2^ACC_W
  assign w_step = ACC_W'(i_freq) * INC;

  // Clear wins over enable so a new note always starts from phase zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_enable) begin
      r_acc <= r_acc + w_step;
    end
  end

  assign o_pwm = r_acc[ACC_W-1] & i_enable & (i_freq != FREQ_W'(REST_FREQ));

endmodule

// File: rtl/music_sequencer.sv
// Runtime-loadable note player: note RAM, sequencing FSM, millisecond
// prescaler and a tone generator driving a 50% duty square wave.
// Ports: clk, reset (sync, active high); bus (slave modport) carries the RAM
// write port, song_len/start/pause/abort/loop_en/tempo_sel controls and the
// pwm/busy/paused/done/cur_index status outputs.
module music_sequencer
  import music_sequencer_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int FREQ_W = 12,
  parameter int DUR_W  = 12,
  parameter int ACC_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  music_sequencer_if.slave   bus
);

  localparam logic [ACC_W-1:0] INC     = ACC_W'(phase_inc(64'(CLK_HZ), ACC_W));
  localparam logic [IDX_W:0]   LEN_MAX = (IDX_W+1)'(DEPTH);

  logic [FREQ_W+DUR_W-1:0] r_mem [DEPTH];
  logic [FREQ_W+DUR_W-1:0] r_rdData;
  logic [1:0]              r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W:0]          r_len;
  logic [FREQ_W-1:0]       r_curFreq;
  logic [DUR_W-1:0]        r_curDur;
  logic [DUR_W-1:0]        r_remaining;
  logic [31:0]             r_prescale;
  logic [31:0]             r_tickMax;
  logic                    r_done;

  logic [1:0]              w_nextState;
  logic [IDX_W-1:0]        w_nextIdx;
  logic                    w_doneSet;
  logic                    w_tick;
  logic                    w_noteEnd;
  logic                    w_lastNote;
  logic                    w_startOk;
  logic                    w_pwm;

  assign w_startOk  = bus.start && (bus.song_len != '0) && (bus.song_len <= LEN_MAX);
  assign w_tick     = (r_state == ST_PLAY) && (r_prescale == r_tickMax);
  // A zero-length note ends after its single PLAY cycle
  assign w_noteEnd  = (r_state == ST_PLAY) &&
                      ((r_curDur == '0) || (w_tick && (r_remaining == DUR_W'(1))));
  assign w_lastNote = ({1'b0, r_idx} == (r_len - (IDX_W+1)'(1)));

  // Next-state logic; abort overrides everything, including end of note
  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    w_doneSet   = 1'b0;
    if (bus.abort) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_startOk) begin
            w_nextState = ST_FETCH;
            w_nextIdx   = '0;
          end
        end
        ST_FETCH: w_nextState = ST_PLAY;
        ST_PLAY: begin
          if (w_noteEnd) begin
            if (!w_lastNote) begin
              w_nextIdx   = r_idx + IDX_W'(1);
              w_nextState = ST_FETCH;
            end else if (bus.loop_en) begin
              w_nextIdx   = '0;
              w_nextState = ST_FETCH;
            end else begin
              w_nextState = ST_IDLE;
              w_doneSet   = 1'b1;
            end
          end else if (bus.pause) begin
            w_nextState = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (!bus.pause) w_nextState = ST_PLAY;
        end
        default: w_nextState = ST_IDLE;
      endcase
    end
  end

  // Note RAM: the read address is the index about to be fetched, so the
  // data is ready during FETCH; a same-cycle write returns the old word
  always_ff @(posedge clk) begin
    if (bus.wr_en) r_mem[bus.wr_addr] <= {bus.wr_freq, bus.wr_dur};
    r_rdData <= r_mem[w_nextIdx];
  end

  // Sequencer registers; prescaler and remaining only move in PLAY, which
  // is what freezes them during PAUSE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_len       <= '0;
      r_curFreq   <= '0;
      r_curDur    <= '0;
      r_remaining <= '0;
      r_prescale  <= '0;
      r_tickMax   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_idx   <= w_nextIdx;
      r_done  <= w_doneSet;
      if ((r_state == ST_IDLE) && (w_nextState == ST_FETCH)) r_len <= bus.song_len;
      if (r_state == ST_FETCH) begin
        r_curFreq   <= r_rdData[FREQ_W+DUR_W-1:DUR_W];
        r_curDur    <= r_rdData[DUR_W-1:0];
        r_remaining <= r_rdData[DUR_W-1:0];
        r_prescale  <= '0;
        r_tickMax   <= tick_cycles(CLK_HZ, bus.tempo_sel) - 32'd1;
      end else if (r_state == ST_PLAY) begin
        if (w_tick) begin
          r_prescale  <= '0;
          r_remaining <= r_remaining - DUR_W'(1);
        end else begin
          r_prescale  <= r_prescale + 32'd1;
        end
      end
    end
  end

  tone_gen #(
    .FREQ_W (FREQ_W),
    .ACC_W  (ACC_W),
    .INC    (INC)
  ) u_toneGen (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (r_state == ST_FETCH),
    .i_enable (r_state == ST_PLAY),
    .i_freq   (r_curFreq),
    .o_pwm    (w_pwm)
  );

  assign bus.pwm       = w_pwm;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.paused    = (r_state == ST_PAUSE);
  assign bus.done      = r_done;
  assign bus.cur_index = r_idx;

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer. Stimulus pushes one expected record
// per note into a queue; an independent monitor segments the DUT outputs into
// notes (by busy and cur_index) and compares each against the queue head.
module tb_music_sequencer;
  localparam int     CLK_HZ = 100_000;
  localparam int     DEPTH  = 8;
  localparam int     IDX_W  = 3;
  localparam int     FREQ_W = 12;
  localparam int     DUR_W  = 12;
  localparam int     ACC_W  = 32;
  localparam longint INC    = 42950;

  typedef struct {
    int idx;
    int active;
    int rises;
    int pausedC;
    bit doneEnd;
    bit partial;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  music_sequencer_if #(.IDX_W(IDX_W), .FREQ_W(FREQ_W), .DUR_W(DUR_W)) bus ();

  music_sequencer #(
    .CLK_HZ (CLK_HZ), .DEPTH (DEPTH), .IDX_W (IDX_W),
    .FREQ_W (FREQ_W), .DUR_W (DUR_W), .ACC_W (ACC_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];
  int   modelFreq[DEPTH];
  int   modelDur[DEPTH];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // PLAY cycles of a note: duration in ms times the tempo-scaled tick length
  function automatic int playCycles(input int dur, input int tempo);
    int tick;
    tick = (tempo == 1) ? 50 : (tempo == 2) ? 200 : 100;
    return (dur == 0) ? 1 : dur * tick;
  endfunction

  // Rising edges of the MSB of k*f*INC (mod 2^32), k = 0..cycles-1, from low
  function automatic int noteRises(input int freq, input int cycles);
    longint unsigned step;
    longint unsigned phase;
    int count;
    bit prev;
    step  = (longint'(freq) * INC) & 64'hFFFF_FFFF;
    count = 0;
    prev  = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      phase = (longint'(k) * step) & 64'hFFFF_FFFF;
      if (phase[31] && !prev) count++;
      prev = phase[31];
    end
    return count;
  endfunction

  task automatic pushNote(input int idx, input int tempo, input int pausedC,
                          input bit doneEnd, input bit partial);
    exp_t e;
    int p;
    p         = playCycles(modelDur[idx], tempo);
    e.idx     = idx;
    e.active  = 1 + p;
    e.rises   = noteRises(modelFreq[idx], p);
    e.pausedC = pausedC;
    e.doneEnd = doneEnd;
    e.partial = partial;
    expQ.push_back(e);
  endtask

  task automatic pushSong(input int len, input int tempo);
    for (int i = 0; i < len; i++) pushNote(i, tempo, 0, i == len - 1, 1'b0);
  endtask

  task automatic tickN(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic writeNote(input int addr, input int freq, input int dur);
    bus.wr_en   = 1'b1;
    bus.wr_addr = IDX_W'(addr);
    bus.wr_freq = FREQ_W'(freq);
    bus.wr_dur  = DUR_W'(dur);
    tickN(1);
    bus.wr_en = 1'b0;
    modelFreq[addr] = freq;
    modelDur[addr]  = dur;
  endtask

  task automatic applyStimulus(input int len, input int tempo, input bit loopEn);
    bus.song_len  = (IDX_W+1)'(len);
    bus.tempo_sel = 2'(tempo);
    bus.loop_en   = loopEn;
    bus.start     = 1'b1;
    tickN(1);
    bus.start = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 6000 && bus.busy; i++) tickN(1);
    checkOutput("reachIdle", bus.busy, 0);
    tickN(2);
  endtask

  task automatic finalizeSeg(input int idx, input int act, input int pc,
                             input int rs, input bit doneSeen);
    exp_t e;
    checkOutput("noteExpected", int'(expQ.size() > 0), 1);
    if (expQ.size() == 0) return;
    e = expQ.pop_front();
    checkOutput("noteIndex", idx, e.idx);
    checkOutput("noteDone", doneSeen, e.doneEnd);
    if (!e.partial) begin
      checkOutput("noteActiveCycles", act, e.active);
      checkOutput("notePwmRises", rs, e.rises);
      checkOutput("notePausedCycles", pc, e.pausedC);
    end
  endtask

  // Monitor: splits the output stream into notes and scores each one
  initial begin : monitor
    bit inSeg;
    bit prevPwm;
    int segIdx, active, pausedC, rises;
    inSeg = 1'b0; prevPwm = 1'b0;
    segIdx = 0; active = 0; pausedC = 0; rises = 0;
    forever begin
      @(negedge clk);
      if (inSeg && !bus.busy) begin
        finalizeSeg(segIdx, active, pausedC, rises, bus.done);
        inSeg = 1'b0;
      end else if (inSeg && int'(bus.cur_index) != segIdx) begin
        finalizeSeg(segIdx, active, pausedC, rises, 1'b0);
        inSeg = 1'b0;
      end else if (inSeg) begin
        if (bus.paused) begin
          pausedC++;
          checkOutput("pwmLowInPause", bus.pwm, 0);
        end else begin
          active++;
          if (bus.pwm && !prevPwm) rises++;
          prevPwm = bus.pwm;
        end
      end else begin
        checkOutput("doneLowWhenIdle", bus.done, 0);
      end
      if (!inSeg && bus.busy) begin
        inSeg   = 1'b1;
        segIdx  = int'(bus.cur_index);
        active  = 1;
        pausedC = 0;
        rises   = 0;
        prevPwm = bus.pwm;
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int len, tempo, e;
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_freq = '0; bus.wr_dur = '0;
    bus.song_len = '0; bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;
    bus.loop_en = 1'b0; bus.tempo_sel = 2'b00;
    tickN(3);
    reset = 1'b0;
    checkOutput("resetBusy", bus.busy, 0);
    checkOutput("resetPwm", bus.pwm, 0);
    checkOutput("resetPaused", bus.paused, 0);
    checkOutput("resetDone", bus.done, 0);
    checkOutput("resetIndex", bus.cur_index, 0);

    writeNote(0, 1000, 2);
    writeNote(1, 0, 1);
    writeNote(2, 500, 1);

    $display("[TB] basic three-note song");
    pushSong(3, 0);
    applyStimulus(3, 0, 1'b0);
    tickN(250);
    checkOutput("midSongIndex", bus.cur_index, 1);
    tickN(152);
    checkOutput("busyBeforeEnd", bus.busy, 1);
    tickN(1);
    checkOutput("busyAtEnd", bus.busy, 0);
    checkOutput("doneAtEnd", bus.done, 1);
    tickN(1);
    checkOutput("doneOneCycle", bus.done, 0);
    waitIdle();

    $display("[TB] loop mode");
    for (int i = 0; i < 3; i++) pushNote(i, 0, 0, 1'b0, 1'b0);
    pushSong(3, 0);
    applyStimulus(3, 0, 1'b1);
    tickN(720);
    checkOutput("loopSecondPassIndex", bus.cur_index, 2);
    bus.loop_en = 1'b0;
    waitIdle();

    $display("[TB] pause during note 0");
    pushNote(0, 0, 250, 1'b0, 1'b0);
    pushNote(1, 0, 0, 1'b0, 1'b0);
    pushNote(2, 0, 0, 1'b1, 1'b0);
    applyStimulus(3, 0, 1'b0);
    tickN(51);
    bus.pause = 1'b1;
    tickN(125);
    checkOutput("pausedFlag", bus.paused, 1);
    checkOutput("pausedPwm", bus.pwm, 0);
    tickN(125);
    bus.pause = 1'b0;
    waitIdle();

    $display("[TB] tempo settings");
    for (int t = 1; t < 4; t++) begin
      pushNote(0, t, 0, 1'b1, 1'b0);
      applyStimulus(1, t, 1'b0);
      waitIdle();
    end

    $display("[TB] abort with pause at final note end");
    pushNote(0, 0, 0, 1'b0, 1'b0);
    pushNote(1, 0, 0, 1'b0, 1'b0);
    e = 2 + playCycles(modelDur[0], 0) + playCycles(modelDur[1], 0);
    applyStimulus(2, 0, 1'b0);
    tickN(e - 1);
    bus.abort = 1'b1;
    bus.pause = 1'b1;
    tickN(1);
    checkOutput("abortBusy", bus.busy, 0);
    checkOutput("abortPwm", bus.pwm, 0);
    checkOutput("abortDone", bus.done, 0);
    bus.abort = 1'b0;
    bus.pause = 1'b0;
    waitIdle();

    $display("[TB] reset during playback");
    pushNote(0, 0, 0, 1'b0, 1'b0);
    pushNote(1, 0, 0, 1'b0, 1'b1);
    applyStimulus(3, 0, 1'b0);
    tickN(250);
    reset = 1'b1;
    tickN(1);
    checkOutput("midResetBusy", bus.busy, 0);
    checkOutput("midResetPwm", bus.pwm, 0);
    checkOutput("midResetPaused", bus.paused, 0);
    checkOutput("midResetDone", bus.done, 0);
    checkOutput("midResetIndex", bus.cur_index, 0);
    reset = 1'b0;
    tickN(2);
    pushSong(3, 0);
    applyStimulus(3, 0, 1'b0);
    waitIdle();

    $display("[TB] rejected song lengths");
    applyStimulus(0, 0, 1'b0);
    tickN(3);
    checkOutput("lenZeroIdle", bus.busy, 0);
    applyStimulus(DEPTH + 1, 0, 1'b0);
    tickN(3);
    checkOutput("lenTooLongIdle", bus.busy, 0);

    $display("[TB] write to a later note during playback");
    pushNote(0, 0, 0, 1'b0, 1'b0);
    pushNote(1, 0, 0, 1'b0, 1'b0);
    applyStimulus(3, 0, 1'b0);
    tickN(20);
    writeNote(2, 2000, 2);
    pushNote(2, 0, 0, 1'b1, 1'b0);
    waitIdle();

    $display("[TB] write and read of the same address in one cycle");
    pushSong(3, 0);
    bus.song_len  = (IDX_W+1)'(3);
    bus.tempo_sel = 2'b00;
    bus.loop_en   = 1'b0;
    bus.start     = 1'b1;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = '0;
    bus.wr_freq   = FREQ_W'(1500);
    bus.wr_dur    = DUR_W'(1);
    tickN(1);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    modelFreq[0] = 1500;
    modelDur[0]  = 1;
    waitIdle();
    pushNote(0, 0, 0, 1'b1, 1'b0);
    applyStimulus(1, 0, 1'b0);
    waitIdle();

    $display("[TB] randomized songs");
    for (int s = 0; s < 6; s++) begin
      for (int a = 0; a < DEPTH; a++)
        writeNote(a, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(100, 3000)),
                  int'($urandom_range(0, 3)));
      len   = int'($urandom_range(2, 5));
      tempo = int'($urandom_range(0, 3));
      pushSong(len, tempo);
      applyStimulus(len, tempo, 1'b0);
      waitIdle();
    end

    tickN(5);
    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/music_sequencer.md
Name: music_sequencer

Overview:
- Parametrised successor to the single-song player.
- Plays a runtime-loadable note list (frequency in Hz, duration in ms) from an internal RAM. Output is a 50%-duty square wave on `pwm`.
- Adds pause/resume, abort, loop mode, programmable song length, tempo scaling, and a done/busy status.
- Sits between the board control logic (keys/switches or a CPU register block) and the buzzer pin.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz; sets the 1 ms tick and the tone increment.
- DEPTH, 256, note RAM entries; power of two, ≥2.
- IDX_W, $clog2(DEPTH), note index width.
- FREQ_W, 12, note frequency field width (Hz; 0 = rest).
- DUR_W, 12, note duration field width (ms).
- ACC_W, 32, tone phase accumulator width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  note RAM write strobe
- wr_addr  in  IDX_W  note RAM write address
- wr_freq  in  FREQ_W  frequency to write
- wr_dur  in  DUR_W  duration to write
- song_len  in  IDX_W+1  number of notes to play (1..DEPTH); sampled at start
- start  in  1  begin playback from index 0 (level; acted on only in IDLE)
- pause  in  1  level; freezes playback while high
- abort  in  1  return to IDLE immediately
- loop_en  in  1  restart at index 0 after the last note instead of finishing
- tempo_sel  in  2  00 ×1, 01 durations ×1/2, 10 durations ×2, 11 treated as ×1
- pwm  out  1  square-wave tone output
- busy  out  1  high in any state other than IDLE
- paused  out  1  high in PAUSE
- done  out  1  one-cycle pulse when a non-looping song completes
- cur_index  out  IDX_W  index of the note being fetched/played

Behaviour:
- Reset (synchronous): state=IDLE, all outputs 0, counters and accumulator 0.
- Reset does not clear the RAM; contents are undefined until written.
- RAM:
  - Write on wr_en at posedge; accepted in every state.
  - Read is synchronous (1-cycle latency).
  - Read and write to the same address in the same cycle returns the old data.
  - A write to a future index during playback takes effect when that index is fetched.
- States: IDLE, FETCH, PLAY, PAUSE.
- IDLE:
  - start=1 and song_len≠0: latch len_r=song_len, idx=0, go FETCH.
  - song_len=0 or song_len>DEPTH: start is ignored and the block stays in IDLE.
- FETCH (1 cycle, RAM read issued on entry):
  - Load cur_freq/cur_dur, remaining=cur_dur, clear the ms prescaler and phase accumulator, go PLAY.
  - First tone edge therefore appears ≥2 cycles after start.
- PLAY:
  - The prescaler counts to TICK-1 then emits a tick, where TICK = CLK_HZ/1000, halved for tempo 01, doubled for tempo 10.
  - tempo_sel is sampled at every FETCH; a change mid-note takes effect on the next note.
  - Each tick decrements remaining.
  - End of note: remaining==0 after a decrement, or cur_dur==0 (zero-duration note lasts 1 cycle in PLAY).
  - At end of note, if idx==len_r-1:
    - loop_en=1: idx=0, FETCH.
    - Otherwise: done pulse, IDLE.
  - At end of note otherwise: idx=idx+1, FETCH.
  - No gap cycles are inserted between notes beyond the FETCH cycle.
- PAUSE:
  - Entered from PLAY when pause=1; resumes to PLAY when pause=0.
  - Prescaler, remaining and accumulator are frozen; pwm is forced 0.
  - pause asserted in FETCH takes effect on arrival in PLAY (1 cycle of PLAY, then PAUSE).
- abort:
  - Highest priority: from any state, next state is IDLE and pwm=0 next cycle.
  - Beats pause, start and end of note in the same cycle; done is not pulsed.
- Tone generation:
  - acc += cur_freq × INC each cycle in PLAY, where INC = round(2^ACC_W / CLK_HZ), a compile-time constant.
  - pwm = acc[ACC_W-1] when cur_freq≠0; pwm = 0 for rests and in IDLE/FETCH/PAUSE.
  - The product is computed in ACC_W bits and wraps modulo 2^ACC_W.
- Outputs:
  - cur_index = idx.
  - busy = (state≠IDLE).
  - done is registered and high for exactly 1 cycle.

Decomposition:
- music_pkg:
  - state enum (IDLE/FETCH/PLAY/PAUSE).
  - tempo_sel codes.
  - function tick_cycles(CLK_HZ, tempo).
  - function phase_inc(CLK_HZ, ACC_W).
  - Rest encoding (freq 0).
- Sub-module tone_gen:
  - Phase accumulator with clear/enable, freq input, pwm output; gated low for rests.
- Sequencer FSM, prescaler and RAM stay in music_sequencer.

Test Plan:
Bench uses CLK_HZ=100_000, so TICK=100 cycles and INC=42950.
- Load 3 notes {1000 Hz/2 ms, 0/1 ms, 500 Hz/1 ms}, song_len=3, pulse start → FETCH→PLAY.
  - pwm toggles with period 100±1 cycles for 200 cycles, then low for 100 cycles, then period 200 cycles for 100 cycles.
  - Exactly one done pulse after 400 PLAY cycles + 3 FETCH cycles; busy falls the same cycle.
- Same song with loop_en=1 → cur_index sequence 0,1,2,0,1…, no done pulse.
  - Deassert loop_en during note 2 → done pulse after that note ends.
- pause held 250 cycles during note 0 at cycle 50 → pwm=0 and paused=1 throughout.
  - Note 0 ends 250 cycles later than the unpaused case; remaining count is unchanged across the pause.
- tempo_sel=01 → note 0 lasts 100 cycles; tempo_sel=10 → 400 cycles; tempo_sel=11 → 200 cycles.
- abort asserted the same cycle as end of final note and pause → IDLE next cycle, pwm=0, done not pulsed.
  - Reset asserted mid-PLAY → all outputs 0 next cycle; a new start plays the unchanged RAM.
- start with song_len=0 → stays IDLE, busy=0.
  - Write to index 2 while playing index 0 → new value is heard at index 2.
  - Same-cycle write/read to the same address → old data is used.
